// File: rtl/link_pkg.sv
// link_pkg: shared link-layer constants and the transmit arbiter state type.
package link_pkg;

  localparam int LINK_PAYLOAD_W = 24;

  // Header codes the link framer places in front of idle fill and payload words.
  localparam logic [7:0] LINK_HEADER_IDLE = 8'h00;
  localparam logic [7:0] LINK_HEADER_DATA = 8'hD5;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/link_tx_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Scans from i_ptr+1 upward,
// wrapping modulo N_REQ, and reports the first requester found.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [2:0]       i_ptr,
  output logic [2:0]       o_winner,
  output logic             o_any
);

  logic [7:0] w_req8;

  assign w_req8 = 8'(i_req);

  // Walk the ring from farthest to nearest so the nearest set request wins.
  always_comb begin
    int idx;
    o_winner = '0;
    o_any    = |i_req;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(i_ptr) + k) % N_REQ;
      if (w_req8[3'(idx)]) o_winner = 3'(idx);
    end
  end

endmodule

// File: rtl/link_tx_arbiter.sv
// link_tx_arbiter: round-robin sharing of the 24-bit link transmit port among
// N_REQ requesters, gated by a remote credit counter.
// Handshake: a grant latches the word and raises transmit_data_valid; the word
// is held until the link pulses transmit_data_consumed, after which req_ack of
// the served requester pulses for one cycle and the arbiter returns to IDLE.
// Optional build macro LINK_ARB_WATCHDOG_EN adds a WAIT-state watchdog and the
// sticky tx_timeout output.
module link_tx_arbiter
  import link_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int CREDITS = 8,
  parameter int TIMEOUT = 256
) (
  input  logic                            clk,
  input  logic                            res,
  input  logic                            cable_connected,
  input  logic [N_REQ-1:0]                req_valid,
  input  logic [N_REQ*LINK_PAYLOAD_W-1:0] req_data,
  output logic [N_REQ-1:0]                req_ack,
  output logic [LINK_PAYLOAD_W-1:0]       transmit_data,
  output logic                            transmit_data_valid,
  input  logic                            transmit_data_consumed,
  input  logic                            credit_return,
  output logic [7:0]                      credits_avail,
  output logic [2:0]                      grant_id,
  output logic                            busy
`ifdef LINK_ARB_WATCHDOG_EN
  ,
  output logic                            tx_timeout
`endif
);

  if (N_REQ < 2 || N_REQ > 8 || CREDITS < 1 || CREDITS > 255 || TIMEOUT < 1) begin : g_bad_params
    $error("link_tx_arbiter: parameter out of range");
  end

  arb_state_t                r_state;
  logic [2:0]                r_ptr;
  logic [LINK_PAYLOAD_W-1:0] r_data;
  logic                      r_valid;
  logic [2:0]                r_grant;
  logic [N_REQ-1:0]          r_ack;
  logic [7:0]                r_credits;

  logic [2:0]                w_winner;
  logic                      w_any;
  logic                      w_dec;
  logic [LINK_PAYLOAD_W-1:0] w_words [8];

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .i_req    (req_valid),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  // Slice the packed payload bus into a fixed 8-entry table indexed by grant.
  for (genvar j = 0; j < 8; j++) begin : g_words
    if (j < N_REQ) begin : g_live
      assign w_words[j] = req_data[j*LINK_PAYLOAD_W +: LINK_PAYLOAD_W];
    end else begin : g_absent
      assign w_words[j] = '0;
    end
  end

  // A word leaves the remote buffer budget when the link consumes it.
  assign w_dec = (r_state == ARB_WAIT) && transmit_data_consumed;

`ifdef LINK_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] r_wd_cnt;
  logic            r_timeout;
  logic            w_wd_expire;

  assign w_wd_expire = (r_wd_cnt == WD_W'(TIMEOUT - 1));
  assign tx_timeout  = r_timeout;

  // Count cycles spent in WAIT; any other state clears the count.
  always_ff @(posedge clk or posedge res) begin
    if (res) r_wd_cnt <= '0;
    else if (r_state == ARB_WAIT) r_wd_cnt <= r_wd_cnt + 1'b1;
    else r_wd_cnt <= '0;
  end
`endif

  // Arbiter FSM: grant from IDLE, hold the word in WAIT until consumed/abort.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state <= ARB_IDLE;
      r_ptr   <= 3'(N_REQ - 1);
      r_data  <= '0;
      r_valid <= 1'b0;
      r_grant <= '0;
      r_ack   <= '0;
`ifdef LINK_ARB_WATCHDOG_EN
      r_timeout <= 1'b0;
`endif
    end else begin
      r_ack <= '0;
      case (r_state)
        ARB_IDLE: begin
          if (cable_connected && (r_credits != 8'd0) && w_any) begin
            r_state <= ARB_WAIT;
            r_data  <= w_words[w_winner];
            r_grant <= w_winner;
            r_valid <= 1'b1;
          end
        end
        ARB_WAIT: begin
          if (transmit_data_consumed) begin
            // Completion wins over a simultaneous cable drop.
            r_state <= ARB_IDLE;
            r_valid <= 1'b0;
            r_ack   <= {{(N_REQ-1){1'b0}}, 1'b1} << r_grant;
            r_ptr   <= r_grant;
          end else if (!cable_connected) begin
            // Pointer untouched so the interrupted requester goes first again.
            r_state <= ARB_IDLE;
            r_valid <= 1'b0;
`ifdef LINK_ARB_WATCHDOG_EN
          end else if (w_wd_expire) begin
            // Stalled requester gives up its priority.
            r_state   <= ARB_IDLE;
            r_valid   <= 1'b0;
            r_ptr     <= r_grant;
            r_timeout <= 1'b1;
`endif
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  // Remote credit counter: returns add, consumes subtract, capped at CREDITS.
  always_ff @(posedge clk or posedge res) begin
    if (res) r_credits <= 8'(CREDITS);
    else if (!cable_connected) r_credits <= 8'(CREDITS);
    else begin
      case ({credit_return, w_dec})
        2'b10:   if (r_credits < 8'(CREDITS)) r_credits <= r_credits + 8'd1;
        2'b01:   r_credits <= r_credits - 8'd1;
        default: r_credits <= r_credits;
      endcase
    end
  end

  assign transmit_data       = r_data;
  assign transmit_data_valid = r_valid;
  assign grant_id            = r_grant;
  assign req_ack             = r_ack;
  assign credits_avail       = r_credits;
  assign busy                = (r_state == ARB_WAIT);

endmodule

// File: tb/tb_link_tx_arbiter.sv
// tb_link_tx_arbiter: directed bench for link_tx_arbiter (N_REQ=4, CREDITS=8).
// Build with LINK_ARB_WATCHDOG_EN to add the watchdog scenario (TIMEOUT=16).
module tb_link_tx_arbiter;

  localparam int N_REQ   = 4;
  localparam int CREDITS = 8;
  localparam int TIMEOUT = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 res;
  logic                 cable_connected;
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ*24-1:0]  req_data;
  logic [N_REQ-1:0]     req_ack;
  logic [23:0]          transmit_data;
  logic                 transmit_data_valid;
  logic                 transmit_data_consumed;
  logic                 credit_return;
  logic [7:0]           credits_avail;
  logic [2:0]           grant_id;
  logic                 busy;
`ifdef LINK_ARB_WATCHDOG_EN
  logic                 tx_timeout;
`endif

  logic [23:0] word [4];
  assign req_data = {word[3], word[2], word[1], word[0]};

  link_tx_arbiter #(.N_REQ(N_REQ), .CREDITS(CREDITS), .TIMEOUT(TIMEOUT)) dut (
    .clk                    (clk),
    .res                    (res),
    .cable_connected        (cable_connected),
    .req_valid              (req_valid),
    .req_data               (req_data),
    .req_ack                (req_ack),
    .transmit_data          (transmit_data),
    .transmit_data_valid    (transmit_data_valid),
    .transmit_data_consumed (transmit_data_consumed),
    .credit_return          (credit_return),
    .credits_avail          (credits_avail),
    .grant_id               (grant_id),
    .busy                   (busy)
`ifdef LINK_ARB_WATCHDOG_EN
    ,
    .tx_timeout             (tx_timeout)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [23:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; outputs are sampled and inputs driven 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    res                    = 1'b1;
    cable_connected        = 1'b1;
    req_valid              = '0;
    transmit_data_consumed = 1'b0;
    credit_return          = 1'b0;
    tick();
    tick();
    res = 1'b0;
  endtask

  // Expects a grant to requester id on the next edge, consumes it immediately,
  // and checks the acknowledge cycle.
  task automatic send_one(input int id, input int cred_after);
    exp_q.push_back(word[id]);
    tick();
    chk("send_valid", 32'(transmit_data_valid), 32'd1);
    chk("send_grant", 32'(grant_id), id);
    chk("send_data", 32'(transmit_data), 32'(exp_q.pop_front()));
    transmit_data_consumed = 1'b1;
    tick();
    transmit_data_consumed = 1'b0;
    chk("send_ack", 32'(req_ack), 1 << id);
    chk("send_valid_low", 32'(transmit_data_valid), 32'd0);
    chk("send_credits", 32'(credits_avail), cred_after);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int id;
    word[0] = 24'hABCDEF;
    word[1] = 24'h111111;
    word[2] = 24'h222222;
    word[3] = 24'h333333;

    // Reset values
    do_reset();
    chk("rst_valid", 32'(transmit_data_valid), 32'd0);
    chk("rst_data", 32'(transmit_data), 32'd0);
    chk("rst_ack", 32'(req_ack), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_credits", 32'(credits_avail), 32'd8);

    // Single requester, one-cycle grant latency
    req_valid = 4'b0001;
    tick();
    chk("t1_valid", 32'(transmit_data_valid), 32'd1);
    chk("t1_data", 32'(transmit_data), 32'hABCDEF);
    chk("t1_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_hold", 32'(transmit_data), 32'hABCDEF);
    transmit_data_consumed = 1'b1;
    tick();
    transmit_data_consumed = 1'b0;
    chk("t1_ack", 32'(req_ack), 32'b0001);
    chk("t1_valid_low", 32'(transmit_data_valid), 32'd0);
    chk("t1_credits", 32'(credits_avail), 32'd7);
    req_valid = 4'b0000;
    tick();
    chk("t1_ack_single", 32'(req_ack), 32'd0);
    // consumed while idle is ignored
    transmit_data_consumed = 1'b1;
    tick();
    transmit_data_consumed = 1'b0;
    chk("idle_consume_credits", 32'(credits_avail), 32'd7);
    chk("idle_consume_ack", 32'(req_ack), 32'd0);

    // All four requesting: round-robin order 0,1,2,3,0
    do_reset();
    req_valid = 4'b1111;
    tick();
    for (int w = 0; w < 5; w++) begin
      id = w % 4;
      chk("rr_valid", 32'(transmit_data_valid), 32'd1);
      chk("rr_grant", 32'(grant_id), id);
      chk("rr_data", 32'(transmit_data), 32'(word[id]));
      tick();
      chk("rr_hold_grant", 32'(grant_id), id);
      tick();
      transmit_data_consumed = 1'b1;
      tick();
      transmit_data_consumed = 1'b0;
      chk("rr_ack", 32'(req_ack), 1 << id);
      chk("rr_valid_low", 32'(transmit_data_valid), 32'd0);
      chk("rr_credits", 32'(credits_avail), 7 - w);
      tick();
      chk("rr_ack_single", 32'(req_ack), 32'd0);
    end

    // Credit exhaustion and recovery by credit_return
    do_reset();
    req_valid = 4'b0001;
    for (int i = 0; i < 6; i++) send_one(0, 7 - i);
    req_valid = 4'b0111;
    send_one(1, 1);
    req_valid = 4'b0101;
    send_one(2, 0);
    req_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", 32'(transmit_data_valid), 32'd0);
      chk("stall_credits", 32'(credits_avail), 32'd0);
    end
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    chk("return_credits", 32'(credits_avail), 32'd1);
    chk("return_valid", 32'(transmit_data_valid), 32'd0);
    send_one(0, 0);
    req_valid = 4'b0000;

    // Return and consume in the same cycle; saturation at CREDITS
    do_reset();
    req_valid = 4'b0001;
    send_one(0, 7);
    send_one(0, 6);
    send_one(0, 5);
    tick();
    chk("both_grant", 32'(transmit_data_valid), 32'd1);
    transmit_data_consumed = 1'b1;
    credit_return          = 1'b1;
    tick();
    transmit_data_consumed = 1'b0;
    credit_return          = 1'b0;
    req_valid              = 4'b0000;
    chk("both_credits", 32'(credits_avail), 32'd5);
    chk("both_ack", 32'(req_ack), 32'b0001);
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    chk("return_inc", 32'(credits_avail), 32'd6);
    do_reset();
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    chk("return_sat", 32'(credits_avail), 32'd8);

    // Cable drop while serving requester 2
    do_reset();
    req_valid = 4'b0001;
    send_one(0, 7);
    req_valid = 4'b0100;
    tick();
    chk("drop_grant", 32'(grant_id), 32'd2);
    cable_connected = 1'b0;
    tick();
    chk("drop_valid", 32'(transmit_data_valid), 32'd0);
    chk("drop_ack", 32'(req_ack), 32'd0);
    chk("drop_busy", 32'(busy), 32'd0);
    chk("drop_credits", 32'(credits_avail), 32'd8);
    req_valid = 4'b1100;
    tick();
    chk("drop_idle_valid", 32'(transmit_data_valid), 32'd0);
    chk("drop_idle_credits", 32'(credits_avail), 32'd8);
    cable_connected = 1'b1;
    tick();
    chk("reconnect_valid", 32'(transmit_data_valid), 32'd1);
    chk("reconnect_grant", 32'(grant_id), 32'd2);
    chk("reconnect_data", 32'(transmit_data), 32'h222222);
    chk("reconnect_credits", 32'(credits_avail), 32'd8);
    transmit_data_consumed = 1'b1;
    tick();
    transmit_data_consumed = 1'b0;
    chk("reconnect_ack", 32'(req_ack), 32'b0100);
    chk("reconnect_cred_dec", 32'(credits_avail), 32'd7);
    req_valid = 4'b1000;
    tick();
    chk("drop2_grant", 32'(grant_id), 32'd3);
    // consumed and cable drop together: completion wins
    cable_connected        = 1'b0;
    transmit_data_consumed = 1'b1;
    tick();
    transmit_data_consumed = 1'b0;
    req_valid              = 4'b0000;
    chk("drop_consume_ack", 32'(req_ack), 32'b1000);
    chk("drop_consume_valid", 32'(transmit_data_valid), 32'd0);
    chk("drop_consume_credits", 32'(credits_avail), 32'd8);
    cable_connected = 1'b1;

`ifdef LINK_ARB_WATCHDOG_EN
    // Watchdog: no consumed for TIMEOUT cycles
    do_reset();
    chk("wd_rst_timeout", 32'(tx_timeout), 32'd0);
    req_valid = 4'b0011;
    tick();
    chk("wd_grant", 32'(grant_id), 32'd0);
    chk("wd_valid", 32'(transmit_data_valid), 32'd1);
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      tick();
      chk("wd_wait_valid", 32'(transmit_data_valid), 32'd1);
    end
    tick();
    chk("wd_abort_valid", 32'(transmit_data_valid), 32'd0);
    chk("wd_abort_timeout", 32'(tx_timeout), 32'd1);
    chk("wd_abort_ack", 32'(req_ack), 32'd0);
    chk("wd_abort_credits", 32'(credits_avail), 32'd8);
    tick();
    chk("wd_next_grant", 32'(grant_id), 32'd1);
    chk("wd_next_valid", 32'(transmit_data_valid), 32'd1);
    transmit_data_consumed = 1'b1;
    tick();
    transmit_data_consumed = 1'b0;
    req_valid              = 4'b0000;
    chk("wd_next_ack", 32'(req_ack), 32'b0010);
    chk("wd_sticky", 32'(tx_timeout), 32'd1);
    do_reset();
    chk("wd_cleared", 32'(tx_timeout), 32'd0);
`endif

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/link_tx_arbiter.md
Name: link_tx_arbiter

Overview:
- Shares the link block's single 24-bit transmit interface (data/valid/consumed) among N local requesters using round-robin arbitration.
- Gates transmission on a remote-credit counter, so the remote receive buffer is never overrun.
- Sits between the request sources (register/command units) and the link.
- Latches the granted word and holds it stable until the link pulses consumed.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- CREDITS, 8, initial and maximum remote credit count (1..255).
- TIMEOUT, 256, cycles to wait for consumed before abort (only with LINK_ARB_WATCHDOG_EN).

Ports:
- clk  in  1  system clock; all logic on posedge.
- res  in  1  asynchronous, active-high reset.
- cable_connected  in  1  link physical presence.
- req_valid  in  N_REQ  per-requester word pending.
- req_data  in  N_REQ*24  requester i payload in bits [24*i+23:24*i].
- req_ack  out  N_REQ  one-cycle pulse: requester i's word was accepted by the link.
- transmit_data  out  24  to link transmit_data.
- transmit_data_valid  out  1  to link transmit_data_valid.
- transmit_data_consumed  in  1  from link; one-cycle pulse.
- credit_return  in  1  one-cycle pulse: the remote side freed one buffer slot.
- credits_avail  out  8  current credit count.
- grant_id  out  3  index of the requester currently being served; valid while busy.
- busy  out  1  high in the WAIT state.
- tx_timeout  out  1  sticky error; port exists only with LINK_ARB_WATCHDOG_EN.

Behaviour:
- Reset values: all outputs 0, except credits_avail = CREDITS. State = IDLE, round-robin pointer = N_REQ-1.
- FSM has two states, IDLE and WAIT.
- IDLE → WAIT requires all of: cable_connected=1, credits_avail>0, and any req_valid set.
  - Winner: first set req_valid scanning from pointer+1, wrapping modulo N_REQ.
  - At that edge, register the winner's data into transmit_data and its index into grant_id.
  - Set transmit_data_valid=1 and busy=1.
  - Latency: req_valid sampled in cycle t gives transmit_data_valid high in cycle t+1.
- WAIT: transmit_data and grant_id are held stable.
- WAIT, consumed=1 at edge c:
  - In cycle c+1: transmit_data_valid=0, req_ack[grant_id] pulses for one cycle, pointer=grant_id, credits decrement by 1, state=IDLE.
  - The next grant can appear at c+2 at the earliest (one dead cycle between words).
- Requester rule: req_valid and req_data must stay stable until req_ack. Data is captured at grant, so the requester may change req_data in the same cycle it sees req_ack. Dropping req_valid before ack is illegal.
- Credits:
  - credit_return increments; consumed decrements.
  - Both in the same cycle: net unchanged.
  - Increment saturates at CREDITS; an extra return is ignored.
  - A decrement at 0 cannot occur, because a grant requires credits>0.
  - While cable_connected=0 the counter is forced to CREDITS.
- Cable drop while in WAIT:
  - Next cycle: transmit_data_valid=0, state=IDLE, no req_ack, pointer unchanged, so the same requester wins again first after reconnect.
  - A consumed arriving in the same cycle as the drop takes precedence and completes normally.
- transmit_data_consumed while in IDLE is ignored.
- req_valid of a requester with index ≥ N_REQ does not exist. grant_id upper bits are 0 when N_REQ<8.

Optional Feature:
- LINK_ARB_WATCHDOG_EN, defined:
  - A cycle counter runs in WAIT and clears on leaving WAIT.
  - On reaching TIMEOUT with no consumed: transmit_data_valid=0, state=IDLE, no req_ack, no credit decrement.
  - Pointer is set to grant_id, so the stalled requester loses priority.
  - tx_timeout is set to 1 and stays set until res.
- LINK_ARB_WATCHDOG_EN, undefined: no counter, no tx_timeout port; WAIT persists until consumed or cable drop.

Decomposition:
- Shared package link_pkg: LINK_PAYLOAD_W=24, LINK_HEADER_IDLE/LINK_HEADER_DATA constants, and the arbiter state enum (ARB_IDLE, ARB_WAIT).
- One natural sub-module, rr_arbiter:
  - Inputs: request vector and pointer. Output: combinational winner index plus an any-request flag.
  - Pointer register stays in link_tx_arbiter.

Test Plan:
- Reset, then req_valid=4'b0001 with data 24'hABCDEF: transmit_data=ABCDEF and valid at t+1; consumed pulse → req_ack=0001 one cycle later; credits 8→7.
- req_valid=4'b1111 held, consumed returned 3 cycles after each grant: grant order 0,1,2,3,0; each req_ack single-cycle; credits reach 3 after 5 words.
- CREDITS=2, no credit_return: two words sent, third requester stalls with valid=0; one credit_return pulse → third word granted next cycle.
- credit_return and consumed in the same cycle with credits=5: credits stay 5. credit_return at 8: stays 8.
- In WAIT for requester 2, cable_connected drops: valid low next cycle, no ack. On reconnect with requesters 2 and 3 pending, requester 2 is granted first; credits read 8 throughout the drop.
- Watchdog build with TIMEOUT=16 and consumed never pulsed: valid falls after 16 WAIT cycles, tx_timeout=1 and sticky, next grant goes to the following requester; res clears tx_timeout.
